// File: rtl/mul_ctrl.sv
// Sequencing FSM for the iterative multiplier: one load strobe, then N_ITER
// step strobes with an iteration index, then a held done flag.
module mul_ctrl #(
    parameter int N_ITER = 32,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             op_clear,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_clear,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             op_done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        EXEC = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_ITER - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clear_q, clear_d;

    // Clear beats start in every state; DONE accepts a new start directly.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        clear_d = op_clear;
        if (op_clear) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (op_start) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    state_d = EXEC;
                    count_d = '0;
                end
                EXEC: begin
                    if (count_q == LastIdx) begin
                        state_d = DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (op_start) begin
                        state_d = LOAD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            clear_q <= clear_d;
        end
    end

    assign dp_load  = (state_q == LOAD);
    assign dp_step  = (state_q == EXEC);
    assign busy     = (state_q == LOAD) || (state_q == EXEC);
    assign op_done  = (state_q == DONE);
    assign dp_clear = clear_q;
    assign count    = count_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: two instances (N_ITER=32 and N_ITER=4)
// driven by the same inputs and compared against a position-based model.
module tb_mul_ctrl;

    localparam int NA  = 32;
    localparam int CWA = 5;
    localparam int NB  = 4;
    localparam int CWB = 2;

    logic clk = 1'b0;
    logic reset, opStart, opClear;

    logic           dpLoadA, dpStepA, dpClearA, busyA, opDoneA;
    logic [CWA-1:0] countA;
    logic           dpLoadB, dpStepB, dpClearB, busyB, opDoneB;
    logic [CWB-1:0] countB;

    always #5 clk = ~clk;

    mul_ctrl #(.N_ITER(NA), .CNT_W(CWA)) dutA (
        .clk(clk), .reset(reset), .op_start(opStart), .op_clear(opClear),
        .dp_load(dpLoadA), .dp_step(dpStepA), .dp_clear(dpClearA),
        .count(countA), .busy(busyA), .op_done(opDoneA)
    );

    mul_ctrl #(.N_ITER(NB), .CNT_W(CWB)) dutB (
        .clk(clk), .reset(reset), .op_start(opStart), .op_clear(opClear),
        .dp_load(dpLoadB), .dp_step(dpStepB), .dp_clear(dpClearB),
        .count(countB), .busy(busyB), .op_done(opDoneB)
    );

    int   checks   = 0;
    int   failures = 0;
    // Model position: -1 idle, 0 load, 1..N step (index pos-1), N+1 done.
    int   posA     = -1;
    int   posB     = -1;
    logic expClr   = 1'b0;

    typedef struct {
        logic rst; logic st; logic cl;
        logic load; logic step; logic clr; logic busy; logic done;
        int   cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic int nextPos(int pos, int n, logic rst, logic st, logic cl);
        if (rst || cl) return -1;
        if ((pos == -1 || pos == n + 1) && st) return 0;
        if (pos >= 0 && pos <= n) return pos + 1;
        return pos;
    endfunction

    function automatic logic [10:0] expVec(int pos, int n, logic clr);
        logic [5:0] c;
        c = (pos >= 1 && pos <= n) ? 6'(pos - 1) : 6'd0;
        return {pos == 0, pos >= 1 && pos <= n, clr, pos >= 0 && pos <= n, pos == n + 1, c};
    endfunction

    task automatic checkVec(string name, logic [10:0] act, logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got load/step/clr/busy/done/cnt=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic check1(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(string name);
        checkVec({name, " A"}, {dpLoadA, dpStepA, dpClearA, busyA, opDoneA, 6'(countA)},
                 expVec(posA, NA, expClr));
        checkVec({name, " B"}, {dpLoadB, dpStepB, dpClearB, busyB, opDoneB, 6'(countB)},
                 expVec(posB, NB, expClr));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare after it.
    task automatic applyStimulus(logic rst, logic st, logic cl, string name);
        reset   = rst;
        opStart = st;
        opClear = cl;
        @(posedge clk);
        posA   = nextPos(posA, NA, rst, st, cl);
        posB   = nextPos(posB, NB, rst, st, cl);
        expClr = !rst && cl;
        #1;
        checkOutput(name);
    endtask

    task automatic runOp(bit pulse, string tag);
        int stepsA = 0;
        int stepsB = 0;
        int doneA  = -1;
        int doneB  = -1;
        applyStimulus(1'b0, 1'b1, 1'b0, {tag, " start"});
        for (int cyc = 1; cyc <= 40; cyc++) begin
            applyStimulus(1'b0, pulse && cyc == 9, 1'b0, tag);
            if (cyc <= NA + 1 && dpStepA === 1'b1) stepsA++;
            if (cyc <= NB + 1 && dpStepB === 1'b1) stepsB++;
            if (doneA < 0 && opDoneA === 1'b1) doneA = cyc;
            if (doneB < 0 && opDoneB === 1'b1) doneB = cyc;
        end
        check1({tag, " stepsA"}, stepsA, NA);
        check1({tag, " doneAtA"}, doneA, NA + 1);
        check1({tag, " stepsB"}, stepsB, NB);
        check1({tag, " doneAtB"}, doneB, NB + 1);
    endtask

    initial begin
        int doneSeen;
        reset   = 1'b1;
        opStart = 1'b1;
        opClear = 1'b0;

        //          rst   st    cl    load  step  clr   busy  done  cnt   (N_ITER=32 expectations)
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].cl, $sformatf("vec%0d model", i));
            checkVec($sformatf("vec%0d table", i),
                     {dpLoadA, dpStepA, dpClearA, busyA, opDoneA, 6'(countA)},
                     {vecs[i].load, vecs[i].step, vecs[i].clr, vecs[i].busy, vecs[i].done,
                      6'(vecs[i].cnt)});
        end

        // Plain run from IDLE, then a back-to-back run from DONE with a stray start mid-EXEC.
        runOp(1'b0, "run idle");
        runOp(1'b1, "run pulse");

        // Abort while count is 10.
        applyStimulus(1'b0, 1'b1, 1'b0, "abort start");
        for (int cyc = 1; cyc <= 11; cyc++) applyStimulus(1'b0, 1'b0, 1'b0, "abort run");
        check1("abort pre count", int'(countA), 10);
        applyStimulus(1'b0, 1'b0, 1'b1, "abort clear");
        check1("abort dp_clear", int'(dpClearA), 1);
        check1("abort dp_step", int'(dpStepA), 0);
        check1("abort count", int'(countA), 0);
        doneSeen = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, "abort idle");
            if (opDoneA === 1'b1 || dpClearA === 1'b1) doneSeen++;
        end
        check1("abort no done/clear", doneSeen, 0);

        // Start and clear together, in IDLE and in DONE.
        applyStimulus(1'b0, 1'b1, 1'b1, "both idle");
        check1("both idle dp_load", int'(dpLoadA), 0);
        check1("both idle dp_clear", int'(dpClearA), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, "reach done start");
        for (int cyc = 0; cyc < 40; cyc++) applyStimulus(1'b0, 1'b0, 1'b0, "reach done");
        check1("reach done op_done", int'(opDoneA), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, "both done");
        check1("both done dp_load", int'(dpLoadA | dpLoadB), 0);
        check1("both done op_done", int'(opDoneA | opDoneB), 0);
        check1("both done dp_clear", int'(dpClearB), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 59) == 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
